// File: rtl/mult_share_arb_pkg.sv
// Shared constants and types for the multiplier-sharing arbiter and its tag FIFO.
package mult_share_arb_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_NUM_REQ   = 4;
  localparam int DEFAULT_TAG_DEPTH = 8;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int TAG_W(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef logic [TAG_W(DEFAULT_NUM_REQ)-1:0] tag_t;

endpackage

// File: rtl/mult_tag_fifo.sv
// In-flight tag FIFO: synchronous, power-of-2 depth, push and pop allowed together when full.
module mult_tag_fifo
  import mult_share_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TAG_DEPTH,
  parameter int W     = TAG_W(DEFAULT_NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count/empty gate every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters; results return in issue order via a tag FIFO.
// Define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_valid_in,
  input  logic [2*WIDTH-1:0]       mul_product,
  input  logic                     mul_valid_out,
  output logic                     busy,
  output logic                     err
);

  localparam int TAG_BITS = TAG_W(NUM_REQ);
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1;

  logic [TAG_BITS-1:0] grant_idx;
  logic                grant_found;
  logic                can_accept;
  logic [TAG_BITS-1:0] head_tag;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  // A result with no tag outstanding is spurious: it is not routed and only flags err.
  assign fifo_pop = mul_valid_out && !fifo_empty;

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
  // NOTE: outputs get defaults before any branch so every path assigns them and no latch is inferred.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_BITS'(i);
      end
    end
  end
`else
  logic [TAG_BITS-1:0] last_grant;

  // NOTE: outputs get defaults before any branch so every path assigns them and no latch is inferred.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[TAG_BITS'((int'(last_grant) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_BITS'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst)            last_grant <= TAG_BITS'(NUM_REQ - 1);
    else if (can_accept) last_grant <= grant_idx;
  end
`endif

  // Grant is withheld in reset so nothing is accepted on a resetting edge.
  assign can_accept = rst && grant_found && (!fifo_full || fifo_pop);
  assign req_ready  = can_accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mul_valid_in <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
      err          <= 1'b0;
    end else begin
      mul_valid_in <= can_accept;
      if (can_accept) begin
        mul_a <= req_a[grant_idx*WIDTH +: WIDTH];
        mul_b <= req_b[grant_idx*WIDTH +: WIDTH];
      end
      resp_valid <= fifo_pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (fifo_pop) resp_product <= mul_product;
      if (mul_valid_out && fifo_empty) err <= 1'b1;
    end
  end

  assign busy = (fifo_count != '0) || mul_valid_in || (|resp_valid);

  mult_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_BITS)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (can_accept),
    .pop   (fifo_pop),
    .din   (grant_idx),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a latency-10 multiplier model; follows MULT_SHARE_ARB_FIXED_PRIO_EN.
module tb_mult_share_arb;
  import mult_share_arb_pkg::*;

  localparam int WIDTH     = 16;
  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 8;
  localparam int LAT       = 10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]       resp_product;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_valid_in;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     mul_valid_out;
  logic                     busy;
  logic                     err;
  logic                     spurious;

  always #5 clk = ~clk;

  mult_share_arb #(
    .WIDTH     (WIDTH),
    .NUM_REQ   (NUM_REQ),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_product  (resp_product),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_in  (mul_valid_in),
    .mul_product   (mul_product),
    .mul_valid_out (mul_valid_out),
    .busy          (busy),
    .err           (err)
  );

  // Pipelined multiplier model, reset together with the arbiter.
  logic [LAT-1:0]     pipe_v;
  logic [2*WIDTH-1:0] pipe_p [LAT];

  always @(posedge clk) begin
    if (!rst) pipe_v <= '0;
    else      pipe_v <= {pipe_v[LAT-2:0], mul_valid_in};
    pipe_p[0] <= mul_a * mul_b;
    for (int k = 1; k < LAT; k++) pipe_p[k] <= pipe_p[k-1];
  end

  assign mul_valid_out = pipe_v[LAT-1] | spurious;
  assign mul_product   = spurious ? 32'hDEAD_BEEF : pipe_p[LAT-1];

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic [2*WIDTH-1:0] p;
    int                 cyc;
  } resp_t;

  typedef struct {
    tag_t               idx;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
  } vec_t;

  resp_t resp_q[$];
  int    cyc       = 0;
  int    issue_cnt = 0;
  int    n_tests   = 0;
  int    n_fail    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid != '0) resp_q.push_back('{resp_valid, resp_product, cyc});
    if (mul_valid_in) issue_cnt <= issue_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_resp(input int n, input int max_cyc, input string name);
    int c;
    c = 0;
    while (resp_q.size() < n && c < max_cyc) begin
      tick();
      c++;
    end
    check(name, resp_q.size(), n);
  endtask

  task automatic run_single(input vec_t v, input string name);
    int    acc_cyc;
    int    issues0;
    resp_t r;
    resp_q.delete();
    issues0 = issue_cnt;
    tick();
    set_op(int'(v.idx), v.a, v.b);
    req_valid = NUM_REQ'(1) << v.idx;
    #1;
    check({name, "_ready"}, req_ready, NUM_REQ'(1) << v.idx);
    acc_cyc = cyc;
    tick();
    req_valid = '0;
    wait_resp(1, LAT + 10, {name, "_count"});
    if (resp_q.size() > 0) begin
      r = resp_q.pop_front();
      check({name, "_valid"}, r.v, NUM_REQ'(1) << v.idx);
      check({name, "_product"}, r.p, v.p);
      check({name, "_latency"}, r.cyc - acc_cyc, LAT + 2);
    end
    check({name, "_issues"}, issue_cnt - issues0, 1);
  endtask

  vec_t vecs[5];
  logic [2*WIDTH-1:0] rr_prod[4];

  initial begin
    resp_t r;
    int    stall;
    bit    got;

    vecs[0] = '{2'd2, 16'd1000,   16'd100,   32'd100000};
    vecs[1] = '{2'd0, 16'hFFFF,   16'hFFFF,  32'hFFFE_0001};
    vecs[2] = '{2'd3, 16'h0000,   16'h1234,  32'h0000_0000};
    vecs[3] = '{2'd1, 16'h8000,   16'h0002,  32'h0001_0000};
    vecs[4] = '{2'd3, 16'h00FF,   16'h0101,  32'h0000_FFFF};
    rr_prod = '{32'd65535, 32'd131070, 32'd196605, 32'd262140};

    spurious  = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_valid = '1;
    rst       = 1'b0;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_mul_valid_in", mul_valid_in, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_product", resp_product, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    req_valid = '0;
    rst       = 1'b1;

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
    tick();
    set_op(1, 16'd7, 16'd9);
    set_op(3, 16'd5, 16'd5);
    req_valid = 4'b1010;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fp_grant%0d", k), req_ready, 4'b0010);
      tick();
    end
    req_valid = '0;
    wait_resp(6, 40, "fp_count");
    for (int j = 0; j < 6 && resp_q.size() > 0; j++) begin
      r = resp_q.pop_front();
      check($sformatf("fp_valid%0d", j), r.v, 4'b0010);
      check($sformatf("fp_product%0d", j), r.p, 32'd63);
    end
`else
    // All four requesters compete; the 9th request meets a full FIFO until the first pop.
    resp_q.delete();
    tick();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, WIDTH'(i + 1), 16'hFFFF);
    req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_grant%0d", k), req_ready, NUM_REQ'(1) << (k % 4));
      tick();
    end
    stall = 0;
    got   = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (req_ready != '0) got = 1'b1;
      else begin
        stall++;
        tick();
      end
    end
    check("full_stall_cycles", stall, 3);
    check("full_pop_coincident", mul_valid_out, 1);
    check("full_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_resp(9, 40, "rr_count");
    for (int j = 0; j < 9 && resp_q.size() > 0; j++) begin
      r = resp_q.pop_front();
      check($sformatf("rr_valid%0d", j), r.v, NUM_REQ'(1) << (j % 4));
      check($sformatf("rr_product%0d", j), r.p, rr_prod[j % 4]);
    end
`endif
    tick();
    check("drain_busy", busy, 0);
    check("drain_err", err, 0);

    for (int i = 0; i < 5; i++) run_single(vecs[i], $sformatf("single%0d", i));

    // Spurious result with nothing in flight.
    resp_q.delete();
    tick();
    check("idle_busy", busy, 0);
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    check("spur_err", err, 1);
    tick();
    tick();
    check("spur_no_resp", resp_q.size(), 0);
    run_single(vecs[0], "after_spur");
    check("err_sticky", err, 1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("err_cleared", err, 0);

    // Reset with three operations outstanding.
    resp_q.delete();
    tick();
    for (int i = 0; i < 3; i++) set_op(i, 16'd300, WIDTH'(i + 2));
    req_valid = 4'b0111;
    tick();
    tick();
    tick();
    req_valid = '1;
    check("mid_busy", busy, 1);
    rst = 1'b0;
    tick();
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_mul_valid_in", mul_valid_in, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    req_valid = '0;
    rst       = 1'b1;
    for (int c = 0; c < LAT + 10; c++) tick();
    check("mid_no_resp", resp_q.size(), 0);
    check("mid_err", err, 0);
    check("mid_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width of the shared multiplier.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TAG_DEPTH, default 8, in-flight tag FIFO depth (power of 2, at least the multiplier latency).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle.
REQ-008 req_a, req_b  in  NUM_REQ*WIDTH  flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 resp_valid  out  NUM_REQ  one-cycle result pulse to the owning requester.
REQ-010 resp_product  out  2*WIDTH  result shared by all requesters; qualified by resp_valid.
REQ-011 mul_a, mul_b  out  WIDTH  operands to the pipelined multiplier.
REQ-012 mul_valid_in  out  1  issue strobe to the multiplier.
REQ-013 mul_product  in  2*WIDTH  and mul_valid_out  in  1: multiplier result.
REQ-014 busy  out  1  high while any operation is in flight; err  out  1  sticky protocol error.

Function
REQ-015 Handshake: requester i is accepted in the cycle where req_valid[i] && req_ready[i]; requesters SHALL hold operands stable until accepted.
REQ-016 req_ready SHALL be combinational: one-hot grant to the selected valid requester, all-zero when no requester is valid or the tag FIFO is full and no pop occurs in the same cycle.
REQ-017 Arbitration SHALL be round-robin: search starts at index last_grant+1 and wraps modulo NUM_REQ; the pointer updates only on an accepted request.
REQ-018 On acceptance, mul_a/mul_b/mul_valid_in SHALL be registered and presented on the next cycle; mul_valid_in SHALL be high for exactly one cycle per accepted request.
REQ-019 Each acceptance SHALL push the requester index (clog2(NUM_REQ) bits) into the tag FIFO on the same edge that registers mul_valid_in.
REQ-020 Each mul_valid_out SHALL pop one tag; on the next cycle resp_valid[tag] SHALL pulse for one cycle with resp_product = mul_product captured at the pop.
REQ-021 Results SHALL be returned in issue order; there is no response backpressure.
REQ-022 A simultaneous push and pop when full SHALL be allowed, leaving the occupancy unchanged.
REQ-023 mul_valid_out with an empty FIFO SHALL be ignored for routing (no resp_valid) and SHALL set err, which stays high until reset.
REQ-024 busy = (FIFO occupancy != 0) || mul_valid_in || any resp_valid.
REQ-025 Issue-to-response latency SHALL be the multiplier latency + 2 cycles.

Reset
REQ-026 While rst is low at a clock edge, the block SHALL clear: req_ready=0, mul_valid_in=0, mul_a=0, mul_b=0, resp_valid=0, resp_product=0, busy=0, err=0, the FIFO empty, and last_grant=NUM_REQ-1 so that requester 0 has first priority.
REQ-027 Reset mid-operation SHALL discard all in-flight tags; multiplier results arriving after reset with an empty FIFO SHALL set err, and the integrator SHALL reset the multiplier together with this block.

Configuration
REQ-028 With MULT_SHARE_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (the lowest valid index wins) and last_grant SHALL be removed.
REQ-029 Without MULT_SHARE_ARB_FIXED_PRIO_EN, the round-robin behaviour of REQ-017 SHALL apply.

Structure
REQ-030 Package mult_share_arb_pkg SHALL hold: the TAG_W function (clog2 of NUM_REQ), the tag typedef, and the default WIDTH/NUM_REQ/TAG_DEPTH constants.
REQ-031 The tag FIFO SHALL be the sub-module mult_tag_fifo (synchronous, with push/pop/full/empty/count, simultaneous push and pop when full, active-low synchronous rst).

Verification
REQ-032 Single request: requester 2 requests a=1000, b=100 -> one mul_valid_in pulse, then resp_valid=4'b0100 with product 100000 at latency+2 after acceptance.
REQ-033 All four requesters valid continuously (a=i+1, b=65535) -> grants in order 0,1,2,3,0,... and each resp_valid pulse carries (i+1)*65535 to requester i.
REQ-034 FIFO full: stall the multiplier's valid_out with a model of latency 10 and TAG_DEPTH=8 -> the 9th request sees req_ready=0 until the first pop, and the accept coincident with that pop succeeds.
REQ-035 Spurious mul_valid_out with busy=0 -> no resp_valid, err=1 and sticky across later traffic; after rst low, err=0.
REQ-036 Reset mid-flight: assert rst with 3 operations outstanding -> all outputs return to 0 next edge; no resp_valid afterward for the discarded tags.
REQ-037 With MULT_SHARE_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid -> requester 1 granted every cycle and requester 3 starved.
